// File: rtl/pwm_dac_output.sv
// pwm_dac_output: converts signed samples from the sine generator into a
// single-bit PWM stream, one sample per PWM frame of 2^(N_FRAC+1) clocks.
// Samples are double-buffered (pending/active), so a new duty takes effect
// only on a frame boundary. A late or absent sample sets a sticky flag.
//
// Ports:
//   clk_i               system clock, rising edge
//   rst_i               asynchronous reset, active low
//   enable_i            run request (level)
//   data_i              signed two's-complement sample, N_FRAC+1 bits
//   data_valid_strobe_i one-cycle strobe qualifying data_i
//   next_data_strobe_o  one-cycle request for the next sample
//   pwm_o               registered PWM output
//   sample_missed_o     sticky: a frame boundary passed without a new sample
//   busy_o              high whenever the FSM is not IDLE
//   missed_count_o      saturating count of missed boundaries (only with
//                       PWM_MISSED_COUNT_EN defined)
//
// Optional feature macro: PWM_MISSED_COUNT_EN
module pwm_dac_output #(
  parameter int unsigned N_FRAC = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [N_FRAC:0]   data_i,
  input  logic              data_valid_strobe_i,
  output logic              next_data_strobe_o,
  output logic              pwm_o,
  output logic              sample_missed_o,
`ifdef PWM_MISSED_COUNT_EN
  output logic              busy_o,
  output logic [7:0]        missed_count_o
`else
  output logic              busy_o
`endif
);

  localparam int unsigned W = N_FRAC + 1;
  localparam logic [W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   active_q, active_d;
  logic [W-1:0]   pending_q, pending_d;
  logic           pending_valid_q, pending_valid_d;
  logic           missed_d;
  logic           miss_evt_c;
  logic           next_data_d;
  logic           pwm_d;
  logic           busy_d;
  logic [W-1:0]   duty_in_c;
  logic           at_max_c;

  // Offset-binary duty: invert the sign bit.
  assign duty_in_c = {~data_i[W-1], data_i[W-2:0]};
  assign at_max_c  = (cnt_q == CNT_MAX);

  // State register and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      active_q           <= '0;
      pending_q          <= '0;
      pending_valid_q    <= 1'b0;
      sample_missed_o    <= 1'b0;
      next_data_strobe_o <= 1'b0;
      pwm_o              <= 1'b0;
      busy_o             <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      active_q           <= active_d;
      pending_q          <= pending_d;
      pending_valid_q    <= pending_valid_d;
      sample_missed_o    <= missed_d;
      next_data_strobe_o <= next_data_d;
      pwm_o              <= pwm_d;
      busy_o             <= busy_d;
    end
  end

  // Next-state, buffering and output decode.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    active_d        = active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    miss_evt_c      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d           = '0;
        pending_valid_d = 1'b0;
        if (enable_i) state_d = PRIME;
      end
      PRIME: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (data_valid_strobe_i) begin
          active_d        = duty_in_c;
          cnt_d           = '0;
          pending_valid_d = 1'b0;
          state_d         = RUN;
        end
      end
      RUN, DRAIN: begin
        cnt_d = cnt_q + W'(1);
        if (enable_i)      state_d = RUN;
        else if (at_max_c) state_d = IDLE;
        else               state_d = DRAIN;

        if (at_max_c) begin
          // Frame boundary: a coincident strobe bypasses the pending slot.
          if (data_valid_strobe_i) begin
            active_d        = duty_in_c;
            pending_valid_d = 1'b0;
          end else if (pending_valid_q) begin
            active_d        = pending_q;
            pending_valid_d = 1'b0;
          end else if (state_d != IDLE) begin
            // Only a boundary leading into another frame can miss a sample.
            miss_evt_c = 1'b1;
          end
        end else if (data_valid_strobe_i) begin
          pending_d       = duty_in_c;
          pending_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    missed_d    = sample_missed_o | miss_evt_c;
    // Request on PRIME entry and at the start of every RUN frame.
    next_data_d = ((state_q == IDLE) && (state_d == PRIME)) ||
                  ((state_d == RUN) && (cnt_d == '0));
    // PWM is computed from next-cycle values so it stays aligned with cnt_q.
    pwm_d       = ((state_d == RUN) || (state_d == DRAIN)) && (cnt_d < active_d);
    busy_d      = (state_d != IDLE);
  end

`ifdef PWM_MISSED_COUNT_EN
  // Saturating count of missed frame boundaries.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      missed_count_o <= 8'd0;
    end else if (miss_evt_c && (missed_count_o != 8'hFF)) begin
      missed_count_o <= missed_count_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_dac_output.sv
// Directed bench for pwm_dac_output (N_FRAC=7, 256-clock frames).
module tb_pwm_dac_output;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       enable_i;
  logic [7:0] data_i;
  logic       data_valid_strobe_i;
  logic       next_data_strobe_o;
  logic       pwm_o;
  logic       sample_missed_o;
  logic       busy_o;
`ifdef PWM_MISSED_COUNT_EN
  logic [7:0] missed_count_o;
`endif

  int checks = 0;
  int passes = 0;

  int   highs, reqs, busy_cnt;
  logic first_bit, last_bit;

  pwm_dac_output #(.N_FRAC(7)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .enable_i            (enable_i),
    .data_i              (data_i),
    .data_valid_strobe_i (data_valid_strobe_i),
    .next_data_strobe_o  (next_data_strobe_o),
    .pwm_o               (pwm_o),
    .sample_missed_o     (sample_missed_o),
`ifdef PWM_MISSED_COUNT_EN
    .busy_o              (busy_o),
    .missed_count_o      (missed_count_o)
`else
    .busy_o              (busy_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One 256-cycle frame starting at counter==0; optionally sends one sample
  // during the cycle whose counter equals send_at.
  task automatic run_frame(input logic send, input logic [7:0] sdata, input int send_at,
                           output int h, output int r, output logic fb, output logic lb);
    h = 0; r = 0; fb = 1'b0; lb = 1'b0;
    for (int i = 0; i < 256; i++) begin
      h += int'(pwm_o);
      r += int'(next_data_strobe_o);
      if (i == 0)   fb = pwm_o;
      if (i == 255) lb = pwm_o;
      data_valid_strobe_i = send && (i == send_at);
      data_i = sdata;
      step();
    end
    data_valid_strobe_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0; enable_i = 1'b0; data_i = 8'h00; data_valid_strobe_i = 1'b0;
    #12;
    check("rst_pwm",    32'(pwm_o), 0);
    check("rst_busy",   32'(busy_o), 0);
    check("rst_req",    32'(next_data_strobe_o), 0);
    check("rst_missed", 32'(sample_missed_o), 0);
    step(); rst_i = 1'b1; step();

    // Strobe in IDLE is ignored.
    data_valid_strobe_i = 1'b1; step(); data_valid_strobe_i = 1'b0; step();
    check("idle_strobe_busy", 32'(busy_o), 0);

    // Enter PRIME then drop enable: back to IDLE, later strobe ignored.
    enable_i = 1'b1; step();
    check("prime_req", 32'(next_data_strobe_o), 1);
    check("prime_busy", 32'(busy_o), 1);
    enable_i = 1'b0; step();
    check("prime_abort_busy", 32'(busy_o), 0);
    data_valid_strobe_i = 1'b1; step(); data_valid_strobe_i = 1'b0; step();
    check("prime_abort_strobe_busy", 32'(busy_o), 0);
    check("prime_abort_pwm", 32'(pwm_o), 0);

    // Start: request, data 0 two cycles later.
    enable_i = 1'b1; step();
    check("start_req_pulse", 32'(next_data_strobe_o), 1);
    step();
    check("start_req_single", 32'(next_data_strobe_o), 0);
    step();
    data_i = 8'h00; data_valid_strobe_i = 1'b1; step(); data_valid_strobe_i = 1'b0;
    check("run_busy", 32'(busy_o), 1);

    // Frame A: duty 128; queue -128.
    run_frame(1'b1, 8'h80, 10, highs, reqs, first_bit, last_bit);
    check("fa_highs", 32'(highs), 128);
    check("fa_reqs", 32'(reqs), 1);
    check("fa_first", 32'(first_bit), 1);
    check("fa_last", 32'(last_bit), 0);

    // Frame B: duty 0; queue 127.
    run_frame(1'b1, 8'h7F, 20, highs, reqs, first_bit, last_bit);
    check("fb_highs", 32'(highs), 0);
    check("fb_reqs", 32'(reqs), 1);
    check("fb_first", 32'(first_bit), 0);

    // Frame C: duty 255; queue 0xC0 (duty 64).
    run_frame(1'b1, 8'hC0, 5, highs, reqs, first_bit, last_bit);
    check("fc_highs", 32'(highs), 255);
    check("fc_first", 32'(first_bit), 1);
    check("fc_last", 32'(last_bit), 0);

    // Frame D: duty 64; 0x20 arrives exactly at counter 255 (duty 160).
    run_frame(1'b1, 8'h20, 255, highs, reqs, first_bit, last_bit);
    check("fd_highs", 32'(highs), 64);
    check("fd_missed", 32'(sample_missed_o), 0);

    // Frame E: duty 160; queue 0xC0.
    run_frame(1'b1, 8'hC0, 30, highs, reqs, first_bit, last_bit);
    check("fe_highs", 32'(highs), 160);
    check("fe_missed", 32'(sample_missed_o), 0);

    // Frame F: duty 64; sample withheld.
    run_frame(1'b0, 8'h00, 0, highs, reqs, first_bit, last_bit);
    check("ff_highs", 32'(highs), 64);
    check("ff_missed", 32'(sample_missed_o), 1);

    // Frame G: duty held at 64; queue 0x00 (duty 128).
    run_frame(1'b1, 8'h00, 10, highs, reqs, first_bit, last_bit);
    check("fg_highs", 32'(highs), 64);
    check("fg_missed_sticky", 32'(sample_missed_o), 1);
`ifdef PWM_MISSED_COUNT_EN
    check("fg_missed_count", 32'(missed_count_o), 1);
`endif

    // Frame H: disable at counter 50, frame runs out then IDLE.
    highs = 0; reqs = 0;
    for (int i = 0; i < 256; i++) begin
      highs += int'(pwm_o);
      reqs  += int'(next_data_strobe_o);
      data_valid_strobe_i = (i == 10);
      data_i = 8'h40;
      if (i == 50) enable_i = 1'b0;
      step();
    end
    data_valid_strobe_i = 1'b0;
    check("drain_highs", 32'(highs), 128);
    check("drain_reqs", 32'(reqs), 1);
    check("drain_busy", 32'(busy_o), 0);
    check("drain_pwm", 32'(pwm_o), 0);
    reqs = 0; busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      reqs     += int'(next_data_strobe_o);
      busy_cnt += int'(busy_o);
      step();
    end
    check("idle_reqs", 32'(reqs), 0);
    check("idle_busy", 32'(busy_cnt), 0);

    // Async reset mid-frame while pwm_o is high.
    enable_i = 1'b1; step();
    data_i = 8'h00; data_valid_strobe_i = 1'b1; step(); data_valid_strobe_i = 1'b0;
    for (int i = 0; i < 100; i++) step();
    check("pre_rst_pwm", 32'(pwm_o), 1);
    check("pre_rst_missed", 32'(sample_missed_o), 1);
    #2 rst_i = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm_o), 0);
    check("async_rst_busy", 32'(busy_o), 0);
    check("async_rst_missed", 32'(sample_missed_o), 0);
    check("async_rst_req", 32'(next_data_strobe_o), 0);
`ifdef PWM_MISSED_COUNT_EN
    check("async_rst_count", 32'(missed_count_o), 0);
`endif

    // After release, a fresh start shows the counter restarted from zero.
    step(); rst_i = 1'b1; enable_i = 1'b1; step();
    data_i = 8'h80; data_valid_strobe_i = 1'b1; step(); data_valid_strobe_i = 1'b0;
    check("restart_req", 32'(next_data_strobe_o), 1);
    check("restart_pwm", 32'(pwm_o), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
